// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter sharing one uart_tx serializer among NUM_REQ byte streams.
// Latency: grant 1 cycle after valid seen in IDLE, uart_start 1 cycle after byte accept.
// Backpressure: req_ready is only offered to the owner in SEND; other requesters wait for IDLE.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = $clog2(NUM_REQ),
    parameter int MAX_PKT_BYTES = 64
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_data,
    output logic                   uart_start,
    input  logic                   uart_busy,
    output logic [ID_W-1:0]        grant_id,
    output logic                   active,
    output logic                   forced_release
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state;
    logic [7:0]        byte_cnt;
    logic              last_q;
    logic              pick_vld;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   scan_idx;

    // Walk the scan from the far end so the candidate nearest grant_id+1 wins.
    always_comb begin
        pick_vld = 1'b0;
        pick_id  = grant_id;
        scan_idx = grant_id;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = ID_W'((int'(grant_id) + k) % NUM_REQ);
            if (req_valid[scan_idx]) begin
                pick_vld = 1'b1;
                pick_id  = scan_idx;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == SEND) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            byte_cnt       <= 8'd0;
            last_q         <= 1'b0;
            uart_data      <= 8'h00;
            uart_start     <= 1'b0;
            grant_id       <= ID_W'(NUM_REQ - 1);
            active         <= 1'b0;
            forced_release <= 1'b0;
        end else begin
            uart_start     <= 1'b0;
            forced_release <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        grant_id <= pick_id;
                        byte_cnt <= 8'd0;
                        active   <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (req_valid[grant_id]) begin
                        uart_data  <= req_data[8*grant_id +: 8];
                        uart_start <= 1'b1;
                        last_q     <= req_last[grant_id];
                        byte_cnt   <= byte_cnt + 8'd1;
                        state      <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (uart_busy) begin
                        state <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!uart_busy) begin
                        if (last_q) begin
                            active <= 1'b0;
                            state  <= IDLE;
                        end else if (byte_cnt == 8'(MAX_PKT_BYTES)) begin
                            // Rest of the packet re-arbitrates as a fresh grant.
                            forced_release <= 1'b1;
                            active         <= 1'b0;
                            state          <= IDLE;
                        end else begin
                            state <= SEND;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
